rs_latch_driver: RTL and testbench
==================================

// Module: rs_latch_driver
// PURPOSE
//  Clocked initiator for a NAND-type RS latch with active-low set/reset inputs.
//  Accepts set/reset commands over a valid/ready handshake and drives timed
//  active-low strobes into the latch. It then reads back q/qn through a 2-flop
//  synchronizer and reports done plus an error flag. It sits between
//  synchronous control logic and the asynchronous latch cell.
// PARAMETERS
//  PULSE_CYC   2  cycles the selected strobe is held low; legal 1..255
//  SETTLE_CYC  3  cycles both strobes are high before q/qn are checked; legal 2..255
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  synchronous reset, active-low
//  req_valid  in   1  command valid
//  req_ready  out  1  driver idle and able to accept a command
//  req_op     in   1  1 = set latch (q=1), 0 = reset latch (q=0); sampled on accept
//  lat_s_n    out  1  latch set input, active-low, registered
//  lat_r_n    out  1  latch reset input, active-low, registered
//  lat_q      in   1  latch q, asynchronous
//  lat_qn     in   1  latch qn, asynchronous
//  done       out  1  one-cycle pulse when a command completes
//  err        out  1  valid only with done: 1 = readback mismatch
//  q_state    out  1  last successfully verified latch state
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
//  - Reset values: state=IDLE, lat_s_n=1, lat_r_n=1, done=0, err=0,
//    q_state=0, sync flops=0, counter=0. req_ready=1 on the first cycle after reset.
//  - req_ready is combinational: it is 1 only in IDLE.
//  - Accept: the command is accepted when req_valid && req_ready at a clk edge.
//    req_op is latched on that edge.
//  - FSM states:
//    - IDLE -> PULSE on accept.
//    - PULSE: the strobe selected by op is 0 for exactly PULSE_CYC cycles.
//      Then PULSE -> SETTLE.
//    - SETTLE: both strobes are 1 for exactly SETTLE_CYC cycles.
//      Then SETTLE -> CHECK.
//    - CHECK: one cycle, then -> IDLE.
//  - Timing: for an accept at edge T, the strobe is low for cycles
//    T+1..T+PULSE_CYC, and done=1 in cycle T+PULSE_CYC+SETTLE_CYC+1.
//    With default parameters, done arrives 6 cycles after accept.
//  - Synchronizer: lat_q and lat_qn each pass through 2 flops every cycle.
//    CHECK uses the synchronized values.
//  - CHECK pass condition: q_sync==op && qn_sync==!op.
//    - Pass: done=1, err=0, q_state<=op.
//    - Otherwise (including q_sync==qn_sync): done=1, err=1, q_state unchanged.
//  - Invariant: lat_s_n and lat_r_n are never both 0, in any cycle or state.
//  - A req_valid seen while busy is ignored (req_ready=0). The requester holds
//    the command until it is accepted.
//  - Back-to-back commands: a new command can be accepted in the cycle after
//    CHECK. Repeating the same op is legal and re-pulses the strobe.
//  - Reset mid-operation: at the next edge the block returns to reset values.
//    Strobes go to 1 immediately and no done is issued for the aborted command.
//  - Counter: 8-bit down-counter. Loaded with PULSE_CYC-1 on entry to PULSE
//    and with SETTLE_CYC-1 on entry to SETTLE. The state advances when the
//    counter reaches 0. There is no wrap-around.
// CONFIGURATION
//  Macro RS_LATCH_DRIVER_INIT_RESET_EN.
//  - Defined: after reset exits, the FSM goes directly to PULSE with op=0, so
//    the latch is forced to a known reset state. req_ready stays 0 until that
//    command finishes. The command reports done/err like a normal command, and
//    q_state=0 on a pass.
//  - Undefined: the FSM enters IDLE after reset. The latch state is left as
//    found and q_state reads 0 until the first verified command.
// TESTING
//  The bench models the latch as 2 NAND gates with a 1 ns delay. Defaults
//  PULSE_CYC=2 and SETTLE_CYC=3 unless stated otherwise.
//  1. Reset held 3 cycles, then released -> strobes are 1/1, req_ready=1,
//     done=0, q_state=0. With the INIT macro defined: lat_r_n=0 for 2 cycles,
//     then done=1, err=0.
//  2. Set command (req_op=1) accepted at edge T -> lat_s_n=0 in T+1..T+2,
//     done=1, err=0 at T+6, q_state=1.
//  3. Reset command (req_op=0) immediately after test 2 -> lat_r_n=0 for 2 cycles,
//     done at T+6, q_state=0.
//  4. Latch model stuck with q=0, then a set command -> done=1, err=1,
//     q_state stays 0.
//  5. req_valid held high for 20 cycles during a busy command -> only one
//     accept per IDLE cycle. A checker confirms strobes are never both 0.
//  6. rst_n=0 at T+1 during a set pulse -> strobes are 1 at the next edge,
//     no done is issued. With PULSE_CYC=1 and SETTLE_CYC=2, done arrives at T+4.

Source files
------------

// File: rtl/rs_latch_driver.sv
// rs_latch_driver: valid/ready sequencer that pulses the active-low set/reset strobes of a
// NAND RS latch and verifies q/qn through a 2-flop synchronizer. Option: RS_LATCH_DRIVER_INIT_RESET_EN.
module rs_latch_driver #(
   parameter int unsigned PULSE_CYC  = 2,
   parameter int unsigned SETTLE_CYC = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   output logic req_ready,
   input  logic req_op,
   output logic lat_s_n,
   output logic lat_r_n,
   input  logic lat_q,
   input  logic lat_qn,
   output logic done,
   output logic err,
   output logic q_state
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PULSE  = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;
   localparam logic [1:0] CHECK  = 2'd3;

   localparam logic [7:0] PULSE_LD  = 8'(PULSE_CYC - 1);
   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

   logic [1:0] state;
   logic [7:0] cnt;
   logic       op;
   logic [1:0] q_sync;
   logic [1:0] qn_sync;
   logic       start;
   logic       start_op;
   logic       pass;

`ifdef RS_LATCH_DRIVER_INIT_RESET_EN
   // Pending power-on reset command; it takes the first IDLE slot and masks req_ready.
   logic init_pend;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         init_pend <= 1'b1;
      end else if (start) begin
         init_pend <= 1'b0;
      end
   end

   always_comb begin
      req_ready = (state == IDLE) && !init_pend;
      start     = (state == IDLE) && (init_pend || req_valid);
      start_op  = init_pend ? 1'b0 : req_op;
   end
`else
   always_comb begin
      req_ready = (state == IDLE);
      start     = req_valid && req_ready;
      start_op  = req_op;
   end
`endif

   assign pass = (q_sync[1] == op) && (qn_sync[1] == ~op);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         op      <= 1'b0;
         lat_s_n <= 1'b1;
         lat_r_n <= 1'b1;
         done    <= 1'b0;
         err     <= 1'b0;
         q_state <= 1'b0;
         q_sync  <= '0;
         qn_sync <= '0;
      end else begin
         q_sync  <= {q_sync[0], lat_q};
         qn_sync <= {qn_sync[0], lat_qn};
         done    <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= PULSE;
                  op      <= start_op;
                  cnt     <= PULSE_LD;
                  // Only the selected strobe drops, so both can never be low together.
                  lat_s_n <= ~start_op;
                  lat_r_n <= start_op;
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  state   <= SETTLE;
                  cnt     <= SETTLE_LD;
                  lat_s_n <= 1'b1;
                  lat_r_n <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  // done/err are registered here so they are presented during CHECK.
                  state <= CHECK;
                  done  <= 1'b1;
                  err   <= ~pass;
                  if (pass) begin
                     q_state <= op;
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            CHECK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs_latch_driver.sv
// Randomized scoreboard bench for rs_latch_driver with a two-NAND latch model (1 ns gate delay).
// Honours RS_LATCH_DRIVER_INIT_RESET_EN when the design is built with it.
module tb_rs_latch_driver;

   parameter int unsigned P = 2;
   parameter int unsigned S = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic req_valid;
   logic req_ready;
   logic req_op;
   logic lat_s_n;
   logic lat_r_n;
   logic lat_q;
   logic lat_qn;
   logic done;
   logic err;
   logic q_state;

   rs_latch_driver #(.PULSE_CYC(P), .SETTLE_CYC(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .lat_s_n   (lat_s_n),
      .lat_r_n   (lat_r_n),
      .lat_q     (lat_q),
      .lat_qn    (lat_qn),
      .done      (done),
      .err       (err),
      .q_state   (q_state)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge number k, cyc == k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Cross-coupled NAND latch, re-evaluated 1 ns after a strobe change.
   logic q_m  = 1'b0;
   logic qn_m = 1'b1;
   logic stuck = 1'b0;
   always @(lat_s_n or lat_r_n) begin
      #1;
      repeat (2) begin
         q_m  = ~(lat_s_n & qn_m);
         qn_m = ~(lat_r_n & q_m);
      end
   end
   assign lat_q  = stuck ? 1'b0 : q_m;
   assign lat_qn = stuck ? 1'b1 : qn_m;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   // One entry per command: accept edge, op, predicted err, and whether it is the automatic init command.
   typedef struct {
      int ta;
      bit op;
      bit err;
      bit init;
   } exp_t;
   exp_t exq[$];
   int   free_edge = 0;

   // Monitor: derives every expected output from the pending command list.
   exp_t mf;
   bit   e_s, e_r, e_done, e_ready, qs;
   always @(posedge clk) begin
      #1;
      if (!rst_n) qs = 1'b0;
      e_s = 1'b1; e_r = 1'b1; e_done = 1'b0; e_ready = 1'b1;
      if (exq.size() > 0) begin
         mf = exq[0];
         if (cyc >= mf.ta) begin
            e_ready = 1'b0;
            if (cyc <= mf.ta + int'(P) - 1) begin
               e_s = !mf.op;
               e_r = mf.op;
            end
            if (cyc == mf.ta + int'(P) + int'(S)) e_done = 1'b1;
         end else if (mf.init) begin
            e_ready = 1'b0;
         end
      end
      chk("lat_s_n", int'(lat_s_n), int'(e_s));
      chk("lat_r_n", int'(lat_r_n), int'(e_r));
      chk("strobes_not_both_low", int'(lat_s_n | lat_r_n), 1);
      chk("req_ready", int'(req_ready), int'(e_ready));
      chk("done", int'(done), int'(e_done));
      if (e_done) begin
         chk("err", int'(err), int'(mf.err));
         if (!mf.err) qs = mf.op;
         void'(exq.pop_front());
      end
      chk("q_state", int'(q_state), int'(qs));
   end

   // Holds req_valid from now until the model's accept edge; returns at the negedge after it.
   task automatic issue(input bit op);
      exp_t e;
      int   ta;
      ta = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
      req_valid = 1'b1;
      req_op    = op;
      e.ta = ta; e.op = op; e.err = stuck && op; e.init = 1'b0;
      exq.push_back(e);
      free_edge = ta + int'(P) + int'(S) + 2;
      for (int i = 0; i < 1000 && cyc < ta; i++) @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      req_op    = 1'($urandom);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      req_valid = 1'b0;
      for (int i = 0; i < 200 && exq.size() > 0; i++) @(negedge clk);
      if (exq.size() > 0) begin
         chk("drain_timeout", exq.size(), 0);
         exq.delete();
      end
      @(negedge clk);
   endtask

   // Reset for n edges; any command in flight is aborted and must not report done.
   task automatic do_reset(input int n);
      exp_t e;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      exq.delete();
`ifdef RS_LATCH_DRIVER_INIT_RESET_EN
      e.ta = cyc + n + 1; e.op = 1'b0; e.err = 1'b0; e.init = 1'b1;
      exq.push_back(e);
`endif
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
`ifdef RS_LATCH_DRIVER_INIT_RESET_EN
      free_edge = e.ta + int'(P) + int'(S) + 2;
`else
      free_edge = cyc + 1;
`endif
   endtask

   initial begin
      req_valid = 1'b0;
      req_op    = 1'b0;
      do_reset(3);
      drain();

      // Set then reset, back to back with valid held.
      issue(1'b1);
      issue(1'b0);
      drain();

      // Readback stuck at q=0/qn=1: a set must fail, a reset passes.
      stuck = 1'b1;
      @(negedge clk);
      issue(1'b1);
      issue(1'b0);
      drain();
      stuck = 1'b0;
      @(negedge clk);

      // Valid held continuously across several busy periods.
      issue(1'b1);
      issue(1'b1);
      issue(1'b0);
      drain();

      // Reset one edge into a set pulse.
      issue(1'b1);
      do_reset(1);
      idle(12);
      drain();

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            drain();
            stuck = 1'($urandom);
            @(negedge clk);
         end
         issue(1'($urandom));
         idle($urandom_range(0, 2));
      end
      drain();
      stuck = 1'b0;
      issue(1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
